// File: rtl/concatenate_replicate.sv
// concatenate_replicate: registered concatenation plus a mode-selected second
// result (replicate / swap / sign-extend), one cycle of latency.
// Optional feature: define CR_PARITY_EN to add the registered 2-bit par output
// (par[1] = XOR of res1, par[0] = XOR of res2).
module concatenate_replicate #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   num1,
  input  logic [WIDTH-1:0]   num2,
  input  logic [1:0]         mode,
  output logic [2*WIDTH-1:0] res1,
  output logic [2*WIDTH-1:0] res2,
  output logic               out_valid
`ifdef CR_PARITY_EN
  ,
  output logic [1:0]         par
`endif
);

  logic [2*WIDTH-1:0] res1_next;
  logic [2*WIDTH-1:0] res2_next;

  // Form both results from the current operands; only loaded when in_valid.
  always_comb begin
    res1_next = {num1, num2};
    res2_next = '0;
    case (mode)
      2'b00:   res2_next = {2{num1}};
      2'b01:   res2_next = {2{num2}};
      2'b10:   res2_next = {num2, num1};
      default: res2_next = {{WIDTH{num1[WIDTH-1]}}, num1};
    endcase
  end

  // Result registers: reset wins, otherwise load on in_valid and hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      res1      <= '0;
      res2      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        res1 <= res1_next;
        res2 <= res2_next;
      end
    end
  end

`ifdef CR_PARITY_EN
  // Parity of the values being loaded, so par stays aligned with res1/res2.
  always_ff @(posedge clk) begin
    if (rst) begin
      par <= 2'b00;
    end else if (in_valid) begin
      par <= {^res1_next, ^res2_next};
    end
  end
`endif

endmodule

// File: tb/tb_concatenate_replicate.sv
// Bench for concatenate_replicate: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against an arithmetic model.
// Define CR_PARITY_EN to also exercise the par output.
module tb_concatenate_replicate;

  localparam int W = 8;
  localparam longint M = longint'(1) << W;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [W-1:0]   num1;
  logic [W-1:0]   num2;
  logic [1:0]     mode;
  logic [2*W-1:0] res1;
  logic [2*W-1:0] res2;
  logic           out_valid;
  logic [1:0]     par;

  int checks   = 0;
  int failures = 0;

  // Model state
  bit     known   = 0;
  longint exp_r1  = 0;
  longint exp_r2  = 0;
  bit     exp_ov  = 0;
  bit [1:0] exp_par = 0;

  concatenate_replicate #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .num1      (num1),
    .num2      (num2),
    .mode      (mode),
    .res1      (res1),
    .res2      (res2),
    .out_valid (out_valid)
`ifdef CR_PARITY_EN
    ,
    .par       (par)
`endif
  );

`ifndef CR_PARITY_EN
  assign par = 2'b00;
`endif

  always #5 clk = ~clk;

  function automatic bit odd_ones(input longint v);
    int n = 0;
    longint x = v;
    for (int i = 0; i < 2 * W; i++) begin
      n += int'(x % 2);
      x = x / 2;
    end
    return bit'(n % 2);
  endfunction

  function automatic longint model_res2(input longint a, input longint b, input int md);
    case (md)
      0: return a * (M + 1);
      1: return b * (M + 1);
      2: return b * M + a;
      default: return (a >= M / 2) ? (M - 1) * M + a : a;
    endcase
  endfunction

  task automatic check_val(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs, take one clock edge, advance the model, settle at the negedge.
  task automatic step(input bit r, input bit v, input int a, input int b, input int md);
    rst = r; in_valid = v;
    num1 = W'(a); num2 = W'(b); mode = 2'(md);
    @(posedge clk);
    if (r) begin
      known = 1; exp_ov = 0; exp_r1 = 0; exp_r2 = 0; exp_par = 0;
    end else if (known) begin
      exp_ov = v;
      if (v) begin
        exp_r1 = longint'(a) * M + longint'(b);
        exp_r2 = model_res2(longint'(a), longint'(b), md);
        exp_par = {odd_ones(exp_r1), odd_ones(exp_r2)};
      end
    end
    @(negedge clk);
  endtask

  // Per-cycle comparison of DUT against the model once reset has been seen.
  always @(negedge clk) begin
    if (known) begin
      check_val("model_res1", longint'(res1), exp_r1);
      check_val("model_res2", longint'(res2), exp_r2);
      check_val("model_out_valid", longint'(out_valid), longint'(exp_ov));
`ifdef CR_PARITY_EN
      check_val("model_par", longint'(par), longint'(exp_par));
`endif
    end
  end

  initial begin
    rst = 0; in_valid = 0; num1 = 0; num2 = 0; mode = 0;
    @(negedge clk);

    step(1, 1, 'hFA, 'h0F, 0);
    step(1, 1, 'hFA, 'h0F, 0);
    check_val("rst_res1", longint'(res1), 0);
    check_val("rst_res2", longint'(res2), 0);
    check_val("rst_out_valid", longint'(out_valid), 0);
    check_val("rst_par", longint'(par), 0);

    step(0, 1, 'hFA, 'h0F, 0);
    check_val("m00_res1", longint'(res1), 'hFA0F);
    check_val("m00_res2", longint'(res2), 'hFAFA);
    check_val("m00_ov", longint'(out_valid), 1);
    step(0, 1, 'hFA, 'h0F, 1);
    check_val("m01_res2", longint'(res2), 'h0F0F);
    check_val("m01_ov", longint'(out_valid), 1);
    step(0, 1, 'hFA, 'h0F, 2);
    check_val("m10_res2", longint'(res2), 'h0FFA);
    step(0, 1, 'hFA, 'h0F, 3);
    check_val("m11_res2", longint'(res2), 'hFFFA);
    check_val("m11_res1", longint'(res1), 'hFA0F);
    check_val("m11_ov", longint'(out_valid), 1);

    step(0, 1, 'h7A, 'h0F, 3);
    check_val("sext_pos_res2", longint'(res2), 'h007A);
    step(0, 0, 'h12, 'h34, 0);
    check_val("hold_res1", longint'(res1), 'h7A0F);
    check_val("hold_res2", longint'(res2), 'h007A);
    check_val("hold_ov", longint'(out_valid), 0);
    step(0, 0, 'h12, 'h34, 1);
    check_val("hold_mode_res2", longint'(res2), 'h007A);

    step(0, 1, 'h01, 'h00, 0);
    check_val("par_res1", longint'(res1), 'h0100);
    check_val("par_res2", longint'(res2), 'h0101);
`ifdef CR_PARITY_EN
    check_val("par_value", longint'(par), 2);
`endif

    step(0, 1, 'hAA, 'h55, 2);
    step(1, 1, 'h33, 'h44, 1);
    check_val("midrst_res1", longint'(res1), 0);
    check_val("midrst_res2", longint'(res2), 0);
    check_val("midrst_ov", longint'(out_valid), 0);
    step(0, 0, 'h33, 'h44, 1);
    check_val("post_rst_ov", longint'(out_valid), 0);
    check_val("post_rst_res1", longint'(res1), 0);
    step(0, 1, 'h80, 'h01, 3);
    check_val("first_after_rst_ov", longint'(out_valid), 1);
    check_val("sext_neg_res2", longint'(res2), 'hFF80);

    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7),
           int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
